// File: rtl/fifo_pkt_writer.sv
// rtl/fifo_pkt_writer.sv - packetizing FIFO write front-end: payload words then an {err, len} trailer
// Optional stall watchdog enabled by defining FIFO_PKT_WRITER_TIMEOUT_EN.
module fifo_pkt_writer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [15:0]           pkt_cnt,
  output logic                  stall_err
);

  localparam int CW = DATA_WIDTH - 1;

  if (MAX_LEN < 1 || MAX_LEN > (2 ** CW) - 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fifo_pkt_writer: illegal MAX_LEN or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {ST_DATA, ST_DROP, ST_TRL} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  err_q;
  logic [15:0]           pkt_cnt_q;
  logic                  accept;

  assign winc    = out_valid_q & ~wfull;
  assign wdata   = out_data_q;
  assign pkt_cnt = pkt_cnt_q;
  assign accept  = s_valid & s_ready;
  assign cnt_d   = cnt_q + 1'b1;

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_DATA: s_ready = ~out_valid_q | ~wfull;
      ST_DROP: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ST_DATA;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (accept) begin
            out_data_q  <= s_data;
            out_valid_q <= 1'b1;
            cnt_q       <= cnt_d;
            if (s_last) begin
              state_q <= ST_TRL;
            end else if (cnt_d == CW'(MAX_LEN)) begin
              err_q   <= 1'b1;
              state_q <= ST_DROP;
            end
          end else if (winc) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_DROP: begin
          // Overlong tail is swallowed; only the output register drains.
          if (winc) out_valid_q <= 1'b0;
          if (accept && s_last) state_q <= ST_TRL;
        end
        ST_TRL: begin
          if (!out_valid_q || winc) begin
            out_data_q  <= {err_q, cnt_q};
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= pkt_cnt_q + 16'd1;
            state_q     <= ST_DATA;
          end
        end
        default: state_q <= ST_DATA;
      endcase
    end
  end

`ifdef FIFO_PKT_WRITER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_cnt_q;
  logic          stall_err_q;

  // Counter saturates at the threshold so a long stall cannot wrap it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else if (out_valid_q && wfull) begin
      if (stall_cnt_q != SW'(TIMEOUT_CYCLES)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (stall_cnt_q == SW'(TIMEOUT_CYCLES - 1)) stall_err_q <= 1'b1;
    end else begin
      stall_cnt_q <= '0;
    end
  end

  assign stall_err = stall_err_q;
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb/tb_fifo_pkt_writer.sv - directed self-checking bench for fifo_pkt_writer
module tb_fifo_pkt_writer;

`ifdef FIFO_PKT_WRITER_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        wfull = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        winc;
  logic [7:0]  wdata;
  logic [15:0] pkt_cnt;
  logic        stall_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] wr_q[$];
  int         wr_cyc[$];
  logic [7:0] exp_q[$];

  fifo_pkt_writer #(.DATA_WIDTH(8), .MAX_LEN(8), .TIMEOUT_CYCLES(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .wfull(wfull), .winc(winc),
    .wdata(wdata), .pkt_cnt(pkt_cnt), .stall_err(stall_err)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;
  always @(negedge wclk) begin
    if (wrst_n && winc) begin
      wr_q.push_back(wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge wclk);
      if (s_ready) acc = 1'b1; else waits++;
    end
    @(posedge wclk); #1;
    acc_cyc = cyc;
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept: data %h never accepted, required acceptance within 100 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    #2;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc: got %b required 0", winc); end
    checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h required 00", wdata); end
    checks++; if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL reset_pkt_cnt: got %h required 0000", pkt_cnt); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL reset_stall_err: got %b required 0", stall_err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    idle(2);
    wrst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int w;
    int first_acc;
    clear_log();
    send_beat(8'hA1, 1'b0, w);
    first_acc = acc_cyc;
    send_beat(8'hA2, 1'b0, w);
    send_beat(8'hA3, 1'b1, w);
    idle(5);
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'h03};
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d: got %h required %h", i, wr_q[i], exp_q[i]); end
      end
      for (int i = 1; i < exp_q.size(); i++) begin
        checks++; if (wr_cyc[i] - wr_cyc[i-1] !== 1) begin errors++; $display("FAIL basic_gap%0d: got %0d cycles required 1", i, wr_cyc[i] - wr_cyc[i-1]); end
      end
      checks++; if (wr_cyc[0] !== first_acc) begin errors++; $display("FAIL basic_latency: write in cycle %0d required %0d", wr_cyc[0], first_acc); end
    end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL basic_pkt_cnt: got %0d required 1", pkt_cnt); end
  endtask

  task automatic test_overflow();
    int w;
    clear_log();
    for (int i = 0; i < 10; i++) begin
      send_beat(8'h10 + 8'(i), (i == 9), w);
      if (i >= 8) begin
        checks++; if (w !== 0) begin errors++; $display("FAIL overflow_ready_beat%0d: waited %0d cycles required 0", i + 1, w); end
      end
    end
    idle(5);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h88};
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL overflow_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow_word%0d: got %h required %h", i, wr_q[i], exp_q[i]); end
      end
    end
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL overflow_pkt_cnt: got %0d required 2", pkt_cnt); end
  endtask

  task automatic test_stall();
    int w;
    clear_log();
    send_beat(8'h61, 1'b0, w);
    wfull = 1'b1;
    s_valid = 1'b1; s_data = 8'h62; s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL stall_winc%0d: got %b required 0", i, winc); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b required 0", i, s_ready); end
      checks++; if (wdata !== 8'h61) begin errors++; $display("FAIL stall_hold%0d: got %h required 61", i, wdata); end
    end
    @(posedge wclk); #1;
    wfull = 1'b0;
    send_beat(8'h62, 1'b0, w);
    send_beat(8'h63, 1'b1, w);
    idle(5);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h03};
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d: got %h required %h", i, wr_q[i], exp_q[i]); end
      end
    end
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL stall_pkt_cnt: got %0d required 3", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    int w;
    clear_log();
    send_beat(8'h5A, 1'b1, w);
    send_beat(8'hC3, 1'b1, w);
    send_beat(8'h7E, 1'b1, w);
    idle(5);
    exp_q = '{8'h5A, 8'h01, 8'hC3, 8'h01, 8'h7E, 8'h01};
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", i, wr_q[i], exp_q[i]); end
      end
    end
    checks++; if (pkt_cnt !== 16'd6) begin errors++; $display("FAIL b2b_pkt_cnt: got %0d required 6", pkt_cnt); end
  endtask

  task automatic test_reset_midpacket();
    int w;
    send_beat(8'h31, 1'b0, w);
    send_beat(8'h32, 1'b0, w);
    wrst_n = 1'b0;
    #2;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rst_mid_winc: got %b required 0", winc); end
    checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL rst_mid_wdata: got %h required 00", wdata); end
    checks++; if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_pkt_cnt: got %h required 0000", pkt_cnt); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL rst_mid_stall_err: got %b required 0", stall_err); end
    idle(2);
    wrst_n = 1'b1;
    idle(2);
    clear_log();
    send_beat(8'h41, 1'b0, w);
    send_beat(8'h42, 1'b1, w);
    idle(5);
    exp_q = '{8'h41, 8'h42, 8'h02};
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rst_mid_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_word%0d: got %h required %h", i, wr_q[i], exp_q[i]); end
      end
    end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_pkt_cnt_after: got %0d required 1", pkt_cnt); end
  endtask

  task automatic test_timeout();
    int w;
    logic exp_err;
    clear_log();
    send_beat(8'h55, 1'b0, w);
    wfull = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge wclk);
      @(negedge wclk);
      exp_err = TEN && (i >= 16);
      if (i >= 14) begin
        checks++; if (stall_err !== exp_err) begin errors++; $display("FAIL timeout_cycle%0d: got %b required %b", i, stall_err, exp_err); end
      end
    end
    @(posedge wclk); #1;
    wfull = 1'b0;
    send_beat(8'h66, 1'b1, w);
    idle(5);
    exp_err = TEN;
    checks++; if (stall_err !== exp_err) begin errors++; $display("FAIL timeout_sticky: got %b required %b", stall_err, exp_err); end
    exp_q = '{8'h55, 8'h66, 8'h02};
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL timeout_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_word%0d: got %h required %h", i, wr_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_midpacket();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_writer.md
FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO word width.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum payload words per packet; legal range 1 to 2^(DATA_WIDTH-1)-1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, stall watchdog threshold.
REQ-004 SHALL have port wclk, input, 1 bit, write-domain clock; reset wrst_n, asynchronous, active-low; clock wclk.
REQ-005 SHALL have port wrst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port s_valid, input, 1 bit, upstream beat valid.
REQ-007 SHALL have port s_ready, output, 1 bit, upstream beat accepted when s_valid and s_ready are both high.
REQ-008 SHALL have port s_data, input, DATA_WIDTH bits, upstream payload.
REQ-009 SHALL have port s_last, input, 1 bit, final beat of packet.
REQ-010 SHALL have port wfull, input, 1 bit, FIFO full from write-pointer logic.
REQ-011 SHALL have port winc, output, 1 bit, FIFO write strobe.
REQ-012 SHALL have port wdata, output, DATA_WIDTH bits, FIFO write data.
REQ-013 SHALL have port pkt_cnt, output, 16 bits, count of trailers written, wraps at 0xFFFF.
REQ-014 SHALL have port stall_err, output, 1 bit, watchdog sticky flag.

Function
REQ-015 SHALL hold one output register (out_data, out_valid); winc = out_valid AND NOT wfull, combinational; wdata = out_data.
REQ-016 SHALL use FSM states DATA, DROP, TRL.
REQ-017 In DATA, s_ready = NOT out_valid OR NOT wfull; an accepted beat loads out_data, sets out_valid, and increments the word count cnt.
REQ-018 In DATA, an accepted beat with s_last high SHALL transition to TRL.
REQ-019 In DATA, an accepted beat without s_last that makes cnt equal MAX_LEN SHALL set err and transition to DROP.
REQ-020 In DROP, s_ready = 1; accepted beats SHALL NOT be written; a beat with s_last SHALL transition to TRL.
REQ-021 In TRL, s_ready = 0; when out_valid = 0 or winc = 1 in the same cycle, the block SHALL load the trailer {err, cnt[DATA_WIDTH-2:0]}, set out_valid, clear cnt and err, increment pkt_cnt, and return to DATA.
REQ-022 If no new load occurs, out_valid SHALL clear in the cycle after winc = 1.
REQ-023 Words SHALL be written in strict order: payload, then trailer; no word is duplicated or lost while wfull toggles.
REQ-024 Latency from beat acceptance to winc SHALL be 1 cycle when wfull = 0.
REQ-025 Throughput SHALL be one word per cycle while wfull = 0, except the one trailer cycle per packet.

Reset
REQ-026 On wrst_n low, the block SHALL asynchronously set state to DATA and clear out_valid, out_data, cnt, err, pkt_cnt, the stall counter and stall_err; winc = 0 during reset.
REQ-027 A packet in progress at reset SHALL be abandoned, with no trailer written.

Configuration
REQ-028 Macro FIFO_PKT_WRITER_TIMEOUT_EN defined: the stall counter SHALL count consecutive cycles with out_valid = 1 and wfull = 1, clear otherwise, and set stall_err when it reaches TIMEOUT_CYCLES.
REQ-029 Once set, stall_err SHALL stay set until reset.
REQ-030 Macro undefined: stall_err SHALL be constant 0 and no counter logic SHALL be present.

Verification (DATA_WIDTH=8, MAX_LEN=8, TIMEOUT_CYCLES=16)
REQ-031 Packet of 0xA1, 0xA2, 0xA3 (last) with wfull = 0 -> winc writes 0xA1, 0xA2, 0xA3, 0x03 on consecutive cycles; pkt_cnt = 1.
REQ-032 10-beat packet -> 8 payload writes, then trailer 0x88; beats 9-10 are accepted with s_ready = 1 and not written.
REQ-033 wfull held high 5 cycles mid-packet -> winc = 0 and s_ready = 0 during the stall; out_data is held; the sequence resumes in order after wfull falls.
REQ-034 Three back-to-back 1-beat packets -> writes X, 0x01, Y, 0x01, Z, 0x01; pkt_cnt = 3.
REQ-035 wrst_n pulsed after 2 beats of a packet -> all outputs are 0; a following 2-beat packet yields trailer 0x02.
REQ-036 With FIFO_PKT_WRITER_TIMEOUT_EN, wfull held 16 cycles with out_valid = 1 -> stall_err = 1 on the 16th cycle and stays 1; without the macro, stall_err = 0.
